box_filter: RTL and testbench

Computes the per-pixel adaptive threshold map for the adaptive-thresholding pipeline. It reads the grayscale source image through the image ROM reader and forms a 3x3 local mean with edge-replicated borders. It subtracts a constant offset and writes one 8-bit threshold per pixel into the threshold memory, which the `threshold` stage consumes. It raises `finished` when the whole map is written.

---
 rtl/box_filter.sv | 145 ++++++++++++++
 tb/tb_box_filter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/box_filter.sv
// Adaptive-threshold map generator: 3x3 edge-replicated box mean of the source
// image minus a constant offset, one pixel every 11 cycles in raster order.
module box_filter #(
    parameter int unsigned WIDTH_BITS  = 8,
    parameter int unsigned HEIGHT_BITS = 8,
    parameter int unsigned OFFSET      = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   finished
);

    localparam logic [1:0] StRead  = 2'd0;
    localparam logic [1:0] StLast  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [WIDTH_BITS-1:0]  ColMax = '1;
    localparam logic [HEIGHT_BITS-1:0] RowMax = '1;
    localparam logic [7:0]             Offset = OFFSET[7:0];

    logic [1:0]             state_q, state_d;
    logic [3:0]             k_q, k_d;
    logic [WIDTH_BITS-1:0]  col_q, col_d;
    logic [HEIGHT_BITS-1:0] row_q, row_d;
    logic [11:0]            acc_q, acc_d;

    logic [1:0]             dx, dy;
    logic [3:0]             row_base;
    logic [WIDTH_BITS-1:0]  tap_col;
    logic [HEIGHT_BITS-1:0] tap_row;
    logic [7:0]             mean, thr;

    // Tap k maps to dy = k/3, dx = k%3 (0 means -1, 2 means +1).
    always_comb begin
        row_base = (k_q >= 4'd6) ? 4'd6 : (k_q >= 4'd3) ? 4'd3 : 4'd0;
        dy       = (k_q >= 4'd6) ? 2'd2 : (k_q >= 4'd3) ? 2'd1 : 2'd0;
        dx       = 2'(k_q - row_base);
    end

    always_comb begin
        unique case (dx)
            2'd0:    tap_col = (col_q == '0) ? col_q : col_q - WIDTH_BITS'(1);
            2'd2:    tap_col = (col_q == ColMax) ? col_q : col_q + WIDTH_BITS'(1);
            default: tap_col = col_q;
        endcase
        unique case (dy)
            2'd0:    tap_row = (row_q == '0) ? row_q : row_q - HEIGHT_BITS'(1);
            2'd2:    tap_row = (row_q == RowMax) ? row_q : row_q + HEIGHT_BITS'(1);
            default: tap_row = row_q;
        endcase
    end

    // 7282/65536 gives floor(sum/9) exactly for every sum up to 2295.
    always_comb begin
        mean = 8'((32'(acc_q) * 32'd7282) >> 16);
        thr  = (mean > Offset) ? mean - Offset : 8'd0;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        col_d   = col_q;
        row_d   = row_q;
        acc_d   = acc_q;
        unique case (state_q)
            StRead: begin
                if (k_q != 4'd0) acc_d = acc_q + 12'(iImageData);
                if (k_q == 4'd8) begin
                    k_d     = 4'd0;
                    state_d = StLast;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StLast: begin
                acc_d   = acc_q + 12'(iImageData);
                state_d = StWrite;
            end
            StWrite: begin
                acc_d = '0;
                if (col_q == ColMax && row_q == RowMax) begin
                    state_d = StDone;
                end else begin
                    state_d = StRead;
                    if (col_q == ColMax) begin
                        col_d = '0;
                        row_d = row_q + HEIGHT_BITS'(1);
                    end else begin
                        col_d = col_q + WIDTH_BITS'(1);
                    end
                end
            end
            StDone: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRead;
            k_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs are gated by reset so a mid-run reset shows zeros immediately.
    always_comb begin
        oImageCol      = '0;
        oImageRow      = '0;
        oThresholdCol  = '0;
        oThresholdRow  = '0;
        oThresholdData = '0;
        oThresholdWren = 1'b0;
        finished       = 1'b0;
        if (!reset) begin
            if (state_q == StRead) begin
                oImageCol = tap_col;
                oImageRow = tap_row;
            end
            if (state_q == StWrite) begin
                oThresholdCol  = col_q;
                oThresholdRow  = row_q;
                oThresholdData = thr;
                oThresholdWren = 1'b1;
            end
            finished = (state_q == StDone);
        end
    end

endmodule

// File: tb/tb_box_filter.sv
// Scoreboard bench for box_filter: two 4x4 instances (OFFSET 7 and 0) read the
// same image; a reference model queues expected writes and a monitor checks them.
module tb_box_filter;

    localparam int WB   = 2;
    localparam int HB   = 2;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] r;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] img [NPIX];

    logic [1:0][WB-1:0] icol;
    logic [1:0][HB-1:0] irow;
    logic [1:0][WB-1:0] tcol;
    logic [1:0][HB-1:0] trow;
    logic [1:0][7:0]    tdata;
    logic [1:0]         twren;
    logic [1:0]         fin;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] rd_q;
        always @(posedge clk) rd_q <= img[{irow[g], icol[g]}];

        box_filter #(
            .WIDTH_BITS (WB),
            .HEIGHT_BITS(HB),
            .OFFSET     (g == 0 ? 7 : 0)
        ) u_dut (
            .clock         (clk),
            .reset         (rst),
            .oImageCol     (icol[g]),
            .oImageRow     (irow[g]),
            .iImageData    (rd_q),
            .oThresholdCol (tcol[g]),
            .oThresholdRow (trow[g]),
            .oThresholdData(tdata[g]),
            .oThresholdWren(twren[g]),
            .finished      (fin[g])
        );
    end

    wr_t exp0[$];
    wr_t exp1[$];
    int  n_total = 0;
    int  n_pass  = 0;

    function automatic int clampi(input int v, input int n);
        if (v < 0) return 0;
        if (v > n - 1) return n - 1;
        return v;
    endfunction

    // Reference: mean of the 9 clamped neighbours, minus offset, floored at 0.
    function automatic logic [7:0] ref_thr(input int c, input int r, input int off);
        int sum;
        int mean;
        sum = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                sum += int'(img[clampi(r + dy, H) * W + clampi(c + dx, W)]);
        mean = sum / 9;
        return (mean > off) ? 8'(mean - off) : 8'd0;
    endfunction

    task automatic push_all();
        wr_t e;
        exp0.delete();
        exp1.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                e.c = 2'(c);
                e.r = 2'(r);
                e.d = ref_thr(c, r, 7);
                exp0.push_back(e);
                e.d = ref_thr(c, r, 0);
                exp1.push_back(e);
            end
    endtask

    task automatic check(input string nm, input int g, input int cyc, input int act,
                         input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, g, cyc, act, want);
    endtask

    int cyc[2];
    int nwr[2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int c, p, k;
            int qs;
            bit have;
            wr_t e;
            if (rst) begin
                check("reset_quiet", g, -1,
                      int'({icol[g], irow[g], tcol[g], trow[g], tdata[g], twren[g], fin[g]}), 0);
                cyc[g] = 0;
                nwr[g] = 0;
            end else begin
                c = cyc[g];
                p = c / 11;
                k = c % 11;
                if (p < NPIX && k < 9) begin
                    check("img_col", g, c, int'(icol[g]), clampi(p % W + k % 3 - 1, W));
                    check("img_row", g, c, int'(irow[g]), clampi(p / W + k / 3 - 1, H));
                end else if (p >= NPIX) begin
                    check("img_addr_done", g, c, int'({icol[g], irow[g]}), 0);
                end
                check("wren", g, c, int'(twren[g]), (k == 10 && p < NPIX) ? 1 : 0);
                check("finished", g, c, int'(fin[g]), (c >= 11 * NPIX) ? 1 : 0);
                if (twren[g]) begin
                    have = 1'b0;
                    if (g == 0) begin
                        if (exp0.size() != 0) begin e = exp0.pop_front(); have = 1'b1; end
                    end else begin
                        if (exp1.size() != 0) begin e = exp1.pop_front(); have = 1'b1; end
                    end
                    if (have) begin
                        check("wr_col", g, c, int'(tcol[g]), int'(e.c));
                        check("wr_row", g, c, int'(trow[g]), int'(e.r));
                        check("wr_data", g, c, int'(tdata[g]), int'(e.d));
                    end else begin
                        check("wr_unexpected", g, c, int'(twren[g]), 0);
                    end
                    nwr[g]++;
                end
                if (c == 11 * NPIX) begin
                    qs = (g == 0) ? exp0.size() : exp1.size();
                    check("writes_left", g, c, qs, 0);
                    check("write_count", g, c, nwr[g], NPIX);
                end
                cyc[g] = c + 1;
            end
        end
    end

    task automatic load_image(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0:       img[i] = 8'd100;
                1:       img[i] = 8'd5;
                2:       img[i] = 8'd0;
                3:       img[i] = 8'd255;
                default: img[i] = 8'($urandom_range(0, 255));
            endcase
        end
        if (kind == 2) img[1 * W + 1] = 8'd255;
    endtask

    task automatic run(input int kind, input bit mid_reset);
        @(posedge clk);
        #1 rst = 1'b1;
        load_image(kind);
        push_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        if (mid_reset) begin
            repeat (50) @(posedge clk);
            #1 rst = 1'b1;
            push_all();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
        repeat (11 * NPIX + 8) @(posedge clk);
    endtask

    initial begin
        run(0, 1'b0);
        run(1, 1'b0);
        run(2, 1'b0);
        run(3, 1'b0);
        run(4, 1'b0);
        run(4, 1'b1);
        run(2, 1'b1);
        run(4, 1'b0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
